tdm_demux_3ch: RTL and testbench

- Receive-side counterpart of the 3:1 channel mux.
- Takes a time-division-multiplexed stream carrying three channels in fixed slot order 0,1,2, with slot 0 marked by a start-of-frame flag.
- Per-beat: emits each beat on its channel's output with a channel strobe.
- Per-frame: once slot 2 is received, emits all three channels together as one frame, using a valid/ready handshake toward the consumer.

---
 rtl/tdm_demux_3ch.sv | 162 ++++++++++++++++
 tb/tb_tdm_demux_3ch.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux_3ch.sv
// rtl/tdm_demux_3ch.sv - three-slot TDM receive demux with per-beat strobe and framed handshake output
// Optional error counter built only when TDM_DEMUX_ERR_CNT_EN is defined.
module tdm_demux_3ch #(
    parameter int W          = 8,
    parameter int STRICT_SOF = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_data,
    input  logic           in_sof,
    output logic [W-1:0]   ch_data,
    output logic [1:0]     ch_sel,
    output logic           ch_strobe,
    output logic           frame_valid,
    input  logic           frame_ready,
    output logic [3*W-1:0] frame_data,
    output logic           sync_err,
    output logic           locked,
    output logic [7:0]     err_count
);

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     slot_q, slot_d;
    logic [W-1:0]   stg0_q, stg0_d;
    logic [W-1:0]   stg1_q, stg1_d;
    logic [W-1:0]   ch_data_q, ch_data_d;
    logic [1:0]     ch_sel_q, ch_sel_d;
    logic           ch_strobe_q, ch_strobe_d;
    logic           sync_err_q, sync_err_d;
    logic [3*W-1:0] frame_data_q, frame_data_d;
    logic           frame_valid_q, frame_valid_d;
    logic           accept;

    // Only a slot-2 beat can overwrite an untaken frame, so that is the only stall case.
    assign in_ready = !(frame_valid_q && !frame_ready && (slot_q == 2'd2) && (state_q == LOCK));
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= HUNT;
            slot_q        <= 2'd0;
            stg0_q        <= '0;
            stg1_q        <= '0;
            ch_data_q     <= '0;
            ch_sel_q      <= 2'd0;
            ch_strobe_q   <= 1'b0;
            sync_err_q    <= 1'b0;
            frame_data_q  <= '0;
            frame_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            stg0_q        <= stg0_d;
            stg1_q        <= stg1_d;
            ch_data_q     <= ch_data_d;
            ch_sel_q      <= ch_sel_d;
            ch_strobe_q   <= ch_strobe_d;
            sync_err_q    <= sync_err_d;
            frame_data_q  <= frame_data_d;
            frame_valid_q <= frame_valid_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        stg0_d        = stg0_q;
        stg1_d        = stg1_q;
        ch_data_d     = ch_data_q;
        ch_sel_d      = ch_sel_q;
        ch_strobe_d   = 1'b0;
        sync_err_d    = 1'b0;
        frame_data_d  = frame_data_q;
        frame_valid_d = frame_valid_q && !frame_ready;

        if (accept) begin
            case (state_q)
                HUNT: begin
                    if (in_sof) begin
                        stg0_d      = in_data;
                        ch_data_d   = in_data;
                        ch_sel_d    = 2'd0;
                        ch_strobe_d = 1'b1;
                        state_d     = LOCK;
                        slot_d      = 2'd1;
                    end
                end
                LOCK: begin
                    if (in_sof && (slot_q != 2'd0)) begin
                        // Resync: the partial frame is abandoned and this beat restarts slot 0.
                        sync_err_d  = 1'b1;
                        stg0_d      = in_data;
                        ch_data_d   = in_data;
                        ch_sel_d    = 2'd0;
                        ch_strobe_d = 1'b1;
                        slot_d      = 2'd1;
                    end else if (!in_sof && (slot_q == 2'd0) && (STRICT_SOF != 0)) begin
                        sync_err_d = 1'b1;
                        state_d    = HUNT;
                        slot_d     = 2'd0;
                    end else begin
                        ch_data_d   = in_data;
                        ch_sel_d    = slot_q;
                        ch_strobe_d = 1'b1;
                        case (slot_q)
                            2'd0: begin
                                stg0_d = in_data;
                                slot_d = 2'd1;
                            end
                            2'd1: begin
                                stg1_d = in_data;
                                slot_d = 2'd2;
                            end
                            default: begin
                                frame_data_d  = {in_data, stg1_q, stg0_q};
                                frame_valid_d = 1'b1;
                                slot_d        = 2'd0;
                            end
                        endcase
                    end
                end
                default: begin
                    state_d = HUNT;
                    slot_d  = 2'd0;
                end
            endcase
        end
    end

    assign ch_data     = ch_data_q;
    assign ch_sel      = ch_sel_q;
    assign ch_strobe   = ch_strobe_q;
    assign sync_err    = sync_err_q;
    assign frame_data  = frame_data_q;
    assign frame_valid = frame_valid_q;
    assign locked      = (state_q == LOCK);

`ifdef TDM_DEMUX_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    // Counts in step with the sync_err pulse and sticks at full scale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= 8'd0;
        end else if (sync_err_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_tdm_demux_3ch.sv
// tb/tb_tdm_demux_3ch.sv - scoreboard bench for tdm_demux_3ch (strict and free-running instances)
module tb_tdm_demux_3ch;

    localparam int W = 8;
`ifdef TDM_DEMUX_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid, in_sof, frame_ready;
    logic [W-1:0]   in_data;
    logic           in_ready, ch_strobe, frame_valid, sync_err, locked;
    logic [W-1:0]   ch_data;
    logic [1:0]     ch_sel;
    logic [3*W-1:0] frame_data;
    logic [7:0]     err_count;

    logic           n_valid, n_sof;
    logic [W-1:0]   n_data;
    logic           n_ready, n_strobe, n_fvalid, n_err, n_locked;
    logic [W-1:0]   n_chdata;
    logic [1:0]     n_sel;
    logic [3*W-1:0] n_fdata;
    logic [7:0]     n_errcnt;

    int total = 0;
    int bad   = 0;

    logic [9:0]  sq[$];
    logic [23:0] fq[$];

    always #5 clk = ~clk;

    tdm_demux_3ch #(.W(W), .STRICT_SOF(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sof(in_sof),
        .ch_data(ch_data), .ch_sel(ch_sel), .ch_strobe(ch_strobe),
        .frame_valid(frame_valid), .frame_ready(frame_ready), .frame_data(frame_data),
        .sync_err(sync_err), .locked(locked), .err_count(err_count)
    );

    tdm_demux_3ch #(.W(W), .STRICT_SOF(0)) dut_ns (
        .clk(clk), .rst_n(rst_n),
        .in_valid(n_valid), .in_ready(n_ready), .in_data(n_data), .in_sof(n_sof),
        .ch_data(n_chdata), .ch_sel(n_sel), .ch_strobe(n_strobe),
        .frame_valid(n_fvalid), .frame_ready(1'b1), .frame_data(n_fdata),
        .sync_err(n_err), .locked(n_locked), .err_count(n_errcnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_cnt(input int n);
        if (!CNT_EN) return 8'd0;
        return (n > 255) ? 8'd255 : n[7:0];
    endfunction

    task automatic send(input logic sof, input logic [7:0] d, input logic exp_strb,
                        input logic [1:0] exp_sel, input logic exp_err);
        if (exp_strb) sq.push_back({exp_sel, d});
        in_valid = 1'b1;
        in_sof   = sof;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        chk("sync_err", sync_err, exp_err);
    endtask

    task automatic send_ns(input logic sof, input logic [7:0] d);
        n_valid = 1'b1;
        n_sof   = sof;
        n_data  = d;
        @(posedge clk);
        #1;
        n_valid = 1'b0;
        n_sof   = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every strobe and every frame handshake must match the next queued expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ch_strobe) begin
                chk("strobe_expected", sq.size() > 0, 1);
                if (sq.size() > 0) chk("strobe_sel_data", {ch_sel, ch_data}, sq.pop_front());
            end
            if (frame_valid && frame_ready) begin
                chk("frame_expected", fq.size() > 0, 1);
                if (fq.size() > 0) chk("frame_data", frame_data, fq.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = '0; frame_ready = 1'b1;
        n_valid = 1'b0; n_sof = 1'b0; n_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_strobe", ch_strobe, 0);
        chk("rst_fvalid", frame_valid, 0);
        chk("rst_fdata", frame_data, 0);
        chk("rst_chdata", ch_data, 0);
        chk("rst_locked", locked, 0);
        chk("rst_errcnt", err_count, 0);
        rst_n = 1'b1;

        // normal frame
        send(1, 8'h11, 1, 0, 0);
        send(0, 8'h22, 1, 1, 0);
        fq.push_back(24'h332211);
        send(0, 8'h33, 1, 2, 0);
        chk("norm_fvalid", frame_valid, 1);
        chk("norm_fdata", frame_data, 24'h332211);
        chk("norm_locked", locked, 1);
        idle();
        chk("norm_fvalid_clr", frame_valid, 0);
        chk("norm_strobe_clr", ch_strobe, 0);

        // hunt
        rst_n = 1'b0;
        idle();
        rst_n = 1'b1;
        send(0, 8'hAA, 0, 0, 0);
        chk("hunt_locked", locked, 0);
        send(0, 8'hBB, 0, 0, 0);
        chk("hunt_locked2", locked, 0);
        chk("hunt_strobe", ch_strobe, 0);
        send(1, 8'h01, 1, 0, 0);
        chk("hunt_lock", locked, 1);
        chk("hunt_sel", ch_sel, 0);
        chk("hunt_data", ch_data, 8'h01);
        send(0, 8'h02, 1, 1, 0);
        fq.push_back(24'h030201);
        send(0, 8'h03, 1, 2, 0);
        idle();

        // mid-frame resync
        send(1, 8'h11, 1, 0, 0);
        send(0, 8'h22, 1, 1, 0);
        send(1, 8'h44, 1, 0, 1);
        chk("resync_locked", locked, 1);
        send(0, 8'h55, 1, 1, 0);
        fq.push_back(24'h665544);
        send(0, 8'h66, 1, 2, 0);
        idle();

        // strict loss of sync
        send(0, 8'h77, 0, 0, 1);
        chk("loss_locked", locked, 0);
        chk("loss_strobe", ch_strobe, 0);
        idle();
        chk("loss_err_clr", sync_err, 0);

        // same beat on the free-running instance
        send_ns(1, 8'h11);
        send_ns(0, 8'h22);
        send_ns(0, 8'h33);
        chk("ns_fdata", n_fdata, 24'h332211);
        send_ns(0, 8'h77);
        chk("ns_strobe", n_strobe, 1);
        chk("ns_sel", n_sel, 0);
        chk("ns_data", n_chdata, 8'h77);
        chk("ns_err", n_err, 0);
        chk("ns_locked", n_locked, 1);

        // backpressure
        frame_ready = 1'b0;
        send(1, 8'h11, 1, 0, 0);
        send(0, 8'h22, 1, 1, 0);
        fq.push_back(24'h332211);
        send(0, 8'h33, 1, 2, 0);
        send(1, 8'h66, 1, 0, 0);
        send(0, 8'h55, 1, 1, 0);
        chk("bp_in_ready", in_ready, 0);
        sq.push_back({2'd2, 8'h44});
        fq.push_back(24'h445566);
        in_valid = 1'b1; in_sof = 1'b0; in_data = 8'h44;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("bp_stall_ready", in_ready, 0);
            chk("bp_hold_fdata", frame_data, 24'h332211);
        end
        frame_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_new_fvalid", frame_valid, 1);
        chk("bp_new_fdata", frame_data, 24'h445566);
        idle();
        chk("bp_fvalid_clr", frame_valid, 0);

        // reset mid-frame with a pending frame
        frame_ready = 1'b0;
        send(1, 8'h0A, 1, 0, 0);
        send(0, 8'h0B, 1, 1, 0);
        send(0, 8'h0C, 1, 2, 0);
        send(1, 8'h01, 1, 0, 0);
        send(0, 8'h02, 1, 1, 0);
        chk("pre_rst_fvalid", frame_valid, 1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_fvalid", frame_valid, 0);
        chk("async_locked", locked, 0);
        chk("async_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        frame_ready = 1'b1;
        chk("post_rst_errcnt", err_count, 0);

        // error count saturation
        send(1, 8'h00, 1, 0, 0);
        for (int i = 1; i <= 300; i++) begin
            send(1, i[7:0], 1, 0, 1);
            if (i == 100) chk("errcnt_100", err_count, exp_cnt(i));
            if (i == 255) chk("errcnt_255", err_count, exp_cnt(i));
        end
        chk("errcnt_300", err_count, exp_cnt(300));
        chk("errcnt_locked", locked, 1);
        idle();
        idle();

        chk("strobe_left", sq.size(), 0);
        chk("frame_left", fq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
